pipeline_ctrl: RTL and testbench
================================

PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 Parameter MEM_TIMEOUT, default 64, MEM_WAIT cycle count at which memTimeout sets.
REQ-002 Parameter CNT_W, default 16, width of the performance counters.
REQ-003 clk  in  1  single clock; all state updates on posedge clk.
REQ-004 rst  in  1  reset, asynchronous, active-high.
REQ-005 forwardEn  in  1  forwarding unit enabled.
REQ-006 src1, src2  in  4 each  ID-stage source register numbers.
REQ-007 twoSrc  in  1  ID instruction reads src2.
REQ-008 exeDest, exeWbEn, exeMemRead  in  4/1/1  EXE-stage destination, write-back enable, load flag.
REQ-009 memDest, memWbEn  in  4/1  MEM-stage destination, write-back enable.
REQ-010 branchTaken  in  1  EXE-stage branch resolved taken.
REQ-011 memAccess  in  1  MEM stage holds a load or store.
REQ-012 sramReady  in  1  memory completes the access this cycle.
REQ-013 pipeReady  out  1  ready to the ID/EX, EX/MEM and MEM/WB stage registers.
REQ-014 ifFreeze  out  1  hold PC and IF/ID register.
REQ-015 ifFlush  out  1  flush IF/ID register.
REQ-016 idFlush  out  1  flush (bubble) into ID/EX register.
REQ-017 hazard  out  1  data hazard detected.
REQ-018 memTimeout  out  1  sticky memory-timeout error.
REQ-019 stallCycles, bubbleCount  out  CNT_W each  performance counters.

Function
REQ-020 memStall = memAccess & ~sramReady; pipeReady = ~memStall, combinational.
REQ-021 Match1 = src1 hits (exeWbEn & exeDest) or (memWbEn & memDest); Match2 is the same for src2, gated by twoSrc.
REQ-022 forwardEn=0: hazard = Match1 | Match2; forwardEn=1: hazard only on an EXE match with exeMemRead=1 (load-use).
REQ-023 ifFlush = branchTaken & pipeReady.
REQ-024 idFlush = pipeReady & (branchTaken | hazard); never asserted while pipeReady=0, because a stage-register flush overrides ready and would destroy held contents.
REQ-025 ifFreeze = memStall | (hazard & ~branchTaken); branch flush beats hazard freeze.
REQ-026 FSM states RUN, MEM_WAIT; RUN->MEM_WAIT on memStall; MEM_WAIT->RUN on sramReady; else hold.
REQ-027 waitCnt clears on entry to MEM_WAIT and increments each MEM_WAIT cycle, saturating at MEM_TIMEOUT.
REQ-028 memTimeout sets when waitCnt reaches MEM_TIMEOUT, stays set until rst, and does not alter stall behaviour.
REQ-029 stallCycles increments each cycle pipeReady=0; saturates at all-ones, no wrap.
REQ-030 bubbleCount increments each cycle hazard & pipeReady & ~branchTaken; saturates at all-ones.
REQ-031 sramReady in the same cycle memAccess rises gives no stall and no MEM_WAIT entry.
REQ-032 Zero-latency control: all control outputs are combinational from inputs; only FSM, waitCnt, memTimeout and counters are registered.

Reset
REQ-033 rst forces state=RUN, waitCnt=0, memTimeout=0, stallCycles=0, bubbleCount=0 immediately, including mid MEM_WAIT.
REQ-034 During rst, combinational outputs follow their inputs; downstream stage registers clear on their own rst.

Structure
REQ-035 Package arm_pipe_pkg holds the FSM state type, register-number width (4) and CNT_W default.
REQ-036 The combinational match/hazard logic is sub-module hazard_detect; the FSM and counters stay in pipeline_ctrl.

Verification
REQ-037 Load-use: forwardEn=1, exeMemRead=1, exeWbEn=1, exeDest=3, src1=3 -> hazard=1, ifFreeze=1, idFlush=1, bubbleCount 0->1.
REQ-038 Forwarded ALU op: forwardEn=1, exeMemRead=0, exeDest=5, src2=5, twoSrc=1 -> hazard=0; with forwardEn=0 -> hazard=1.
REQ-039 Memory wait: memAccess=1, sramReady=0 for 5 cycles, then 1 -> pipeReady=0 for 5 cycles, MEM_WAIT then RUN, stallCycles=5.
REQ-040 Branch during stall: branchTaken=1 with memStall -> ifFlush=idFlush=0 until sramReady=1, then both 1 for that cycle.
REQ-041 Timeout and reset: MEM_TIMEOUT=4, sramReady held 0 for 6 cycles -> memTimeout=1 at 4th MEM_WAIT cycle; assert rst mid-wait -> state RUN, counters 0, memTimeout=0.

Source files
------------

// File: rtl/arm_pipe_pkg.sv
// Shared types and constants for the pipeline control slice.
// Holds the stall FSM state type, register-number width and counter width default.
package arm_pipe_pkg;

    localparam int REG_W         = 4;
    localparam int CNT_W_DEFAULT = 16;

    typedef enum logic {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } ctrlState_t;

    // A source register hits a producing stage only when that stage will write back.
    function automatic logic regHit(
        input logic [REG_W-1:0] src,
        input logic [REG_W-1:0] dest,
        input logic             wbEn
    );
        return wbEn && (src == dest);
    endfunction

endpackage

// File: rtl/hazard_detect.sv
// Combinational RAW hazard detection between the ID stage and the EXE/MEM producers.
// With forwarding enabled, only a load in EXE feeding the ID instruction must stall.
module hazard_detect
    import arm_pipe_pkg::*;
(
    input  logic             forwardEn_i,
    input  logic [REG_W-1:0] src1_i,
    input  logic [REG_W-1:0] src2_i,
    input  logic             twoSrc_i,
    input  logic [REG_W-1:0] exeDest_i,
    input  logic             exeWbEn_i,
    input  logic             exeMemRead_i,
    input  logic [REG_W-1:0] memDest_i,
    input  logic             memWbEn_i,
    output logic             hazard_o
);

    logic exeHit1;
    logic exeHit2;
    logic memHit1;
    logic memHit2;
    logic match1;
    logic match2;
    logic exeMatch;

    always_comb begin
        exeHit1  = regHit(src1_i, exeDest_i, exeWbEn_i);
        exeHit2  = twoSrc_i && regHit(src2_i, exeDest_i, exeWbEn_i);
        memHit1  = regHit(src1_i, memDest_i, memWbEn_i);
        memHit2  = twoSrc_i && regHit(src2_i, memDest_i, memWbEn_i);
        match1   = exeHit1 || memHit1;
        match2   = exeHit2 || memHit2;
        exeMatch = exeHit1 || exeHit2;

        if (forwardEn_i) begin
            hazard_o = exeMatch && exeMemRead_i;
        end else begin
            hazard_o = match1 || match2;
        end
    end

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline stall/flush controller: combinational freeze/flush decisions plus a
// memory-wait FSM with sticky timeout detection and saturating performance counters.
module pipeline_ctrl
    import arm_pipe_pkg::*;
#(
    parameter int MEM_TIMEOUT = 64,
    parameter int CNT_W       = CNT_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             forwardEn,
    input  logic [REG_W-1:0] src1,
    input  logic [REG_W-1:0] src2,
    input  logic             twoSrc,
    input  logic [REG_W-1:0] exeDest,
    input  logic             exeWbEn,
    input  logic             exeMemRead,
    input  logic [REG_W-1:0] memDest,
    input  logic             memWbEn,
    input  logic             branchTaken,
    input  logic             memAccess,
    input  logic             sramReady,
    output logic             pipeReady,
    output logic             ifFreeze,
    output logic             ifFlush,
    output logic             idFlush,
    output logic             hazard,
    output logic             memTimeout,
    output logic [CNT_W-1:0] stallCycles,
    output logic [CNT_W-1:0] bubbleCount
);

    localparam int                WAIT_W   = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MEM_TIMEOUT);

    ctrlState_t        state_q;
    ctrlState_t        state_d;
    logic [WAIT_W-1:0] waitCnt_q;
    logic [WAIT_W-1:0] waitCnt_d;
    logic              memTimeout_q;
    logic              memTimeout_d;
    logic [CNT_W-1:0]  stallCycles_q;
    logic [CNT_W-1:0]  stallCycles_d;
    logic [CNT_W-1:0]  bubbleCount_q;
    logic [CNT_W-1:0]  bubbleCount_d;
    logic              memStall;
    logic              bubbleEvent;

    hazard_detect u_hazard (
        .forwardEn_i  (forwardEn),
        .src1_i       (src1),
        .src2_i       (src2),
        .twoSrc_i     (twoSrc),
        .exeDest_i    (exeDest),
        .exeWbEn_i    (exeWbEn),
        .exeMemRead_i (exeMemRead),
        .memDest_i    (memDest),
        .memWbEn_i    (memWbEn),
        .hazard_o     (hazard)
    );

    // Flushes are gated by pipeReady so held stage-register contents survive a stall.
    always_comb begin
        memStall    = memAccess && !sramReady;
        pipeReady   = !memStall;
        ifFlush     = branchTaken && pipeReady;
        idFlush     = pipeReady && (branchTaken || hazard);
        ifFreeze    = memStall || (hazard && !branchTaken);
        bubbleEvent = hazard && pipeReady && !branchTaken;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN:      if (memStall)  state_d = MEM_WAIT;
            MEM_WAIT: if (sramReady) state_d = RUN;
            default:  state_d = RUN;
        endcase
    end

    // Registered bookkeeping derived from the FSM; it never feeds back into stall control.
    always_comb begin
        waitCnt_d = waitCnt_q;
        case (state_q)
            RUN: begin
                if (state_d == MEM_WAIT) waitCnt_d = '0;
            end
            MEM_WAIT: begin
                if (waitCnt_q != WAIT_MAX) waitCnt_d = waitCnt_q + 1'b1;
            end
            default: waitCnt_d = '0;
        endcase

        memTimeout_d  = memTimeout_q || ((state_q == MEM_WAIT) && (waitCnt_d == WAIT_MAX));
        stallCycles_d = stallCycles_q;
        bubbleCount_d = bubbleCount_q;
        if (!pipeReady && (stallCycles_q != '1)) stallCycles_d = stallCycles_q + 1'b1;
        if (bubbleEvent && (bubbleCount_q != '1)) bubbleCount_d = bubbleCount_q + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            waitCnt_q     <= '0;
            memTimeout_q  <= 1'b0;
            stallCycles_q <= '0;
            bubbleCount_q <= '0;
        end else begin
            waitCnt_q     <= waitCnt_d;
            memTimeout_q  <= memTimeout_d;
            stallCycles_q <= stallCycles_d;
            bubbleCount_q <= bubbleCount_d;
        end
    end

    assign memTimeout  = memTimeout_q;
    assign stallCycles = stallCycles_q;
    assign bubbleCount = bubbleCount_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed self-checking bench for pipeline_ctrl with hand-computed expectations.
// Uses a short timeout and narrow counters so timeout and saturation are reachable.
module tb_pipeline_ctrl;
    import arm_pipe_pkg::*;

    logic       clk;
    logic       rst;
    logic       forwardEn;
    logic [3:0] src1;
    logic [3:0] src2;
    logic       twoSrc;
    logic [3:0] exeDest;
    logic       exeWbEn;
    logic       exeMemRead;
    logic [3:0] memDest;
    logic       memWbEn;
    logic       branchTaken;
    logic       memAccess;
    logic       sramReady;
    logic       pipeReady;
    logic       ifFreeze;
    logic       ifFlush;
    logic       idFlush;
    logic       hazard;
    logic       memTimeout;
    logic [3:0] stallCycles;
    logic [3:0] bubbleCount;

    int compareCount  = 0;
    int mismatchCount = 0;

    pipeline_ctrl #(
        .MEM_TIMEOUT (4),
        .CNT_W       (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .forwardEn   (forwardEn),
        .src1        (src1),
        .src2        (src2),
        .twoSrc      (twoSrc),
        .exeDest     (exeDest),
        .exeWbEn     (exeWbEn),
        .exeMemRead  (exeMemRead),
        .memDest     (memDest),
        .memWbEn     (memWbEn),
        .branchTaken (branchTaken),
        .memAccess   (memAccess),
        .sramReady   (sramReady),
        .pipeReady   (pipeReady),
        .ifFreeze    (ifFreeze),
        .ifFlush     (ifFlush),
        .idFlush     (idFlush),
        .hazard      (hazard),
        .memTimeout  (memTimeout),
        .stallCycles (stallCycles),
        .bubbleCount (bubbleCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compareCount++;
        if (observed !== expected) begin
            mismatchCount++;
            $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
        end
    endtask

    // Inputs change just after a falling edge; the #1 lets combinational outputs settle.
    task automatic applyStimulus(
        input logic fwd, input logic [3:0] s1, input logic [3:0] s2, input logic two,
        input logic [3:0] ed, input logic ewb, input logic emr,
        input logic [3:0] md, input logic mwb,
        input logic br, input logic ma, input logic sr
    );
        forwardEn   = fwd;
        src1        = s1;
        src2        = s2;
        twoSrc      = two;
        exeDest     = ed;
        exeWbEn     = ewb;
        exeMemRead  = emr;
        memDest     = md;
        memWbEn     = mwb;
        branchTaken = br;
        memAccess   = ma;
        sramReady   = sr;
        #1;
    endtask

    task automatic nextCycle();
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("reset.state", 32'(dut.state_q), 32'(RUN));
        checkOutput("reset.stallCycles", 32'(stallCycles), 0);
        checkOutput("reset.bubbleCount", 32'(bubbleCount), 0);
        checkOutput("reset.memTimeout", 32'(memTimeout), 0);
        checkOutput("reset.pipeReady", 32'(pipeReady), 1);
        checkOutput("reset.hazard", 32'(hazard), 0);

        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        checkOutput("inReset.pipeReady", 32'(pipeReady), 0);
        checkOutput("inReset.ifFreeze", 32'(ifFreeze), 1);
        nextCycle();
        checkOutput("inReset.stallHeld", 32'(stallCycles), 0);
        checkOutput("inReset.stateHeld", 32'(dut.state_q), 32'(RUN));

        rst = 1'b0;
        applyStimulus(1, 3, 0, 0, 3, 1, 1, 0, 0, 0, 0, 0);
        checkOutput("loadUse.hazard", 32'(hazard), 1);
        checkOutput("loadUse.ifFreeze", 32'(ifFreeze), 1);
        checkOutput("loadUse.idFlush", 32'(idFlush), 1);
        checkOutput("loadUse.ifFlush", 32'(ifFlush), 0);
        checkOutput("loadUse.bubbleBefore", 32'(bubbleCount), 0);
        nextCycle();
        checkOutput("loadUse.bubbleAfter", 32'(bubbleCount), 1);

        applyStimulus(1, 0, 5, 1, 5, 1, 0, 0, 0, 0, 0, 0);
        checkOutput("fwdAlu.hazard", 32'(hazard), 0);
        checkOutput("fwdAlu.idFlush", 32'(idFlush), 0);
        nextCycle();
        checkOutput("fwdAlu.bubble", 32'(bubbleCount), 1);

        applyStimulus(0, 0, 5, 1, 5, 1, 0, 0, 0, 0, 0, 0);
        checkOutput("noFwdAlu.hazard", 32'(hazard), 1);
        checkOutput("noFwdAlu.ifFreeze", 32'(ifFreeze), 1);
        nextCycle();
        checkOutput("noFwdAlu.bubble", 32'(bubbleCount), 2);

        applyStimulus(0, 0, 5, 0, 5, 1, 0, 0, 0, 0, 0, 0);
        checkOutput("oneSrc.hazard", 32'(hazard), 0);
        nextCycle();

        applyStimulus(0, 7, 0, 0, 7, 0, 0, 7, 1, 0, 0, 0);
        checkOutput("memHit.hazard", 32'(hazard), 1);
        nextCycle();
        checkOutput("memHit.bubble", 32'(bubbleCount), 3);

        applyStimulus(1, 7, 0, 0, 7, 0, 1, 7, 1, 0, 0, 0);
        checkOutput("memHitFwd.hazard", 32'(hazard), 0);
        nextCycle();

        applyStimulus(0, 7, 0, 0, 7, 0, 0, 7, 1, 1, 0, 0);
        checkOutput("brHaz.hazard", 32'(hazard), 1);
        checkOutput("brHaz.ifFreeze", 32'(ifFreeze), 0);
        checkOutput("brHaz.idFlush", 32'(idFlush), 1);
        checkOutput("brHaz.ifFlush", 32'(ifFlush), 1);
        nextCycle();
        checkOutput("brHaz.bubble", 32'(bubbleCount), 3);

        for (int i = 0; i < 5; i++) begin
            applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
            checkOutput("memWait.pipeReady", 32'(pipeReady), 0);
            nextCycle();
        end
        checkOutput("memWait.state", 32'(dut.state_q), 32'(MEM_WAIT));
        checkOutput("memWait.stallCycles", 32'(stallCycles), 5);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
        checkOutput("memDone.pipeReady", 32'(pipeReady), 1);
        nextCycle();
        checkOutput("memDone.state", 32'(dut.state_q), 32'(RUN));
        checkOutput("memDone.stallCycles", 32'(stallCycles), 5);
        checkOutput("memDone.timeoutSticky", 32'(memTimeout), 1);

        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0);
        checkOutput("brStall.ifFlush", 32'(ifFlush), 0);
        checkOutput("brStall.idFlush", 32'(idFlush), 0);
        checkOutput("brStall.ifFreeze", 32'(ifFreeze), 1);
        nextCycle();
        checkOutput("brStall.stallCycles", 32'(stallCycles), 6);
        checkOutput("brStall.state", 32'(dut.state_q), 32'(MEM_WAIT));
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1);
        checkOutput("brRelease.ifFlush", 32'(ifFlush), 1);
        checkOutput("brRelease.idFlush", 32'(idFlush), 1);
        nextCycle();
        checkOutput("brRelease.state", 32'(dut.state_q), 32'(RUN));

        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
        checkOutput("fastMem.pipeReady", 32'(pipeReady), 1);
        nextCycle();
        checkOutput("fastMem.state", 32'(dut.state_q), 32'(RUN));
        checkOutput("fastMem.stallCycles", 32'(stallCycles), 6);

        for (int i = 0; i < 11; i++) begin
            applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
            nextCycle();
        end
        checkOutput("stallSaturate", 32'(stallCycles), 15);
        checkOutput("preRst.state", 32'(dut.state_q), 32'(MEM_WAIT));

        rst = 1'b1;
        #1;
        checkOutput("midRst.state", 32'(dut.state_q), 32'(RUN));
        checkOutput("midRst.stallCycles", 32'(stallCycles), 0);
        checkOutput("midRst.bubbleCount", 32'(bubbleCount), 0);
        checkOutput("midRst.memTimeout", 32'(memTimeout), 0);
        checkOutput("midRst.waitCnt", 32'(dut.waitCnt_q), 0);
        nextCycle();
        rst = 1'b0;

        for (int e = 1; e <= 6; e++) begin
            nextCycle();
            checkOutput("timeout.memTimeout", 32'(memTimeout), (e >= 5) ? 32'd1 : 32'd0);
        end
        checkOutput("timeout.waitCntSat", 32'(dut.waitCnt_q), 4);
        checkOutput("timeout.pipeReady", 32'(pipeReady), 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
        nextCycle();
        checkOutput("timeout.stateRun", 32'(dut.state_q), 32'(RUN));
        checkOutput("timeout.sticky", 32'(memTimeout), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
        $finish;
    end

endmodule
